seg_dice_decoder: RTL and testbench

Receive-side decoder for the dice display bus: samples the active-low 7-segment pattern driven by the dice controller and debounces it. Once the pattern has been stable, the block turns it back into a face value 1..6 and pulses a valid strobe. It also keeps optional per-face roll statistics. It sits on the consumer end of the `seg` bus, for example in a test harness or a scoring unit.

---
 rtl/seg_dice_decoder_if.sv | 24 ++
 rtl/seg_dice_decoder.sv | 172 +++++++++++++++++
 tb/tb_seg_dice_decoder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/seg_dice_decoder_if.sv
// Dice display bus seen from the decoder: segment input, decoded face/strobes, stats access.
// Latency: none (wiring only).
// Backpressure: none; the display bus is free-running and cannot be stalled.
interface seg_dice_decoder_if #(
    parameter int CNT_W = 16
);
    logic [6:0]       seg;
    logic [2:0]       face;
    logic             face_valid;
    logic             invalid;
    logic             clear_cnt;
    logic [2:0]       cnt_sel;
    logic [CNT_W-1:0] cnt_out;

    modport master (
        output seg, clear_cnt, cnt_sel,
        input  face, face_valid, invalid, cnt_out
    );

    modport slave (
        input  seg, clear_cnt, cnt_sel,
        output face, face_valid, invalid, cnt_out
    );
endinterface

// File: rtl/seg_dice_decoder.sv
// Debounces the active-low 7-seg dice pattern, decodes face 1..6; stats gated by SEG_DICE_DEC_STATS_EN.
// Latency: pulse in the cycle after the pattern's STABLE_CYCLES+1'th consecutive sampling edge.
// Backpressure: none; pulses are single-cycle and must be consumed when asserted.
module seg_dice_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    seg_dice_decoder_if.slave bus
);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [7:0] STAB_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] STAB_ACC  = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [6:0]       seg_q;
    logic [7:0]       stab;
    logic [2:0]       face_r;
    logic             face_valid_r;
    logic             invalid_r;
    logic             seg_chg;
    logic [2:0]       seg_face;
    logic             accept_face;
    logic             accept_inv;
    logic [CNT_W-1:0] cnt_mux;

    function automatic logic [2:0] decode_face(input logic [6:0] p);
        case (p)
            7'b1111001: return 3'd1;
            7'b0100100: return 3'd2;
            7'b0110000: return 3'd3;
            7'b0011001: return 3'd4;
            7'b0010010: return 3'd5;
            7'b0000010: return 3'd6;
            default:    return 3'd0;
        endcase
    endfunction

    assign seg_chg  = (bus.seg != seg_q);
    assign seg_face = decode_face(seg_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q <= SEG_BLANK;
            stab  <= '0;
        end else begin
            seg_q <= bus.seg;
            if (seg_chg) begin
                stab <= '0;
            end else if (stab < STAB_MAX) begin
                stab <= stab + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Acceptance fires on the edge where stab would reach STABLE_CYCLES, so the
    // strobe registers in the same edge rather than one cycle later.
    always_comb begin
        state_next  = state;
        accept_face = 1'b0;
        accept_inv  = 1'b0;
        unique case (state)
            IDLE: begin
                if (seg_chg) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (!seg_chg && stab >= STAB_ACC) begin
                    if (seg_face != 3'd0) begin
                        accept_face = 1'b1;
                        state_next  = HOLD;
                    end else if (seg_q == SEG_BLANK) begin
                        state_next  = IDLE;
                    end else begin
                        accept_inv  = 1'b1;
                        state_next  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (seg_chg) begin
                    state_next = SETTLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            face_r       <= 3'd0;
            face_valid_r <= 1'b0;
            invalid_r    <= 1'b0;
        end else begin
            face_valid_r <= accept_face;
            invalid_r    <= accept_inv;
            if (accept_face) begin
                face_r <= seg_face;
            end
        end
    end

    assign bus.face       = face_r;
    assign bus.face_valid = face_valid_r;
    assign bus.invalid    = invalid_r;

`ifdef SEG_DICE_DEC_STATS_EN
    logic [CNT_W-1:0] cnt_face [1:6];
    logic [CNT_W-1:0] cnt_inv;

    // Clear wins over a same-edge event; the strobe itself is unaffected.
    always_ff @(posedge clk) begin
        if (reset || bus.clear_cnt) begin
            for (int i = 1; i <= 6; i++) begin
                cnt_face[i] <= '0;
            end
            cnt_inv <= '0;
        end else begin
            for (int i = 1; i <= 6; i++) begin
                if (accept_face && seg_face == 3'(i) && cnt_face[i] != '1) begin
                    cnt_face[i] <= cnt_face[i] + CNT_W'(1);
                end
            end
            if (accept_inv && cnt_inv != '1) begin
                cnt_inv <= cnt_inv + CNT_W'(1);
            end
        end
    end

    always_comb begin
        cnt_mux = '0;
        case (bus.cnt_sel)
            3'd0:    cnt_mux = cnt_inv;
            3'd1:    cnt_mux = cnt_face[1];
            3'd2:    cnt_mux = cnt_face[2];
            3'd3:    cnt_mux = cnt_face[3];
            3'd4:    cnt_mux = cnt_face[4];
            3'd5:    cnt_mux = cnt_face[5];
            3'd6:    cnt_mux = cnt_face[6];
            default: cnt_mux = '0;
        endcase
    end
`else
    logic unused_stats;
    assign unused_stats = ^{bus.clear_cnt, bus.cnt_sel};
    assign cnt_mux      = '0;
`endif

    assign bus.cnt_out = cnt_mux;

    a_pulse_excl: assert property (@(posedge clk) disable iff (reset)
        !(face_valid_r && invalid_r));
    a_face_range: assert property (@(posedge clk) disable iff (reset)
        face_valid_r |-> (face_r inside {[3'd1:3'd6]}));
endmodule

// File: tb/tb_seg_dice_decoder.sv
// Bench for seg_dice_decoder: directed scenarios plus random patterns against a run-length model.
module tb_seg_dice_decoder;
    localparam int         N     = 4;
    localparam int         CW    = 3;
    localparam int         CMAX  = (1 << CW) - 1;
    localparam logic [6:0] BLANK = 7'b1111111;
`ifdef SEG_DICE_DEC_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg_dice_decoder_if #(.CNT_W(CW)) bus();

    seg_dice_decoder #(.STABLE_CYCLES(N), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [6:0] face_tab [1:6] = '{7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010};

    int n_vec = 0;
    int n_bad = 0;

    // Reference: a pattern is accepted when its run of identical samples hits N+1 edges.
    logic [6:0] m_prev = BLANK;
    int         m_run  = 0;
    logic [2:0] m_face = 3'd0;
    logic       m_fv   = 1'b0;
    logic       m_inv  = 1'b0;
    int         m_cnt [0:6];
    int         fv_seen  = 0;
    int         inv_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_cnt(input logic [2:0] sel);
        return (sel == 3'd7 || !STATS_EN) ? 0 : m_cnt[sel];
    endfunction

    task automatic model_edge(input logic [6:0] s, input logic clr, input logic rst);
        int hit = 0;
        if (rst) begin
            m_prev = BLANK;
            m_run  = 0;
            m_face = 3'd0;
            m_fv   = 1'b0;
            m_inv  = 1'b0;
            for (int i = 0; i < 7; i++) m_cnt[i] = 0;
            return;
        end
        if (s != m_prev) m_run = 1;
        else if (m_run < 1000) m_run++;
        m_prev = s;
        m_fv   = 1'b0;
        m_inv  = 1'b0;
        if (m_run == N + 1 && s != BLANK) begin
            for (int f = 1; f <= 6; f++) if (face_tab[f] == s) hit = f;
            if (hit != 0) begin
                m_face = 3'(hit);
                m_fv   = 1'b1;
            end else begin
                m_inv = 1'b1;
            end
        end
        if (clr) begin
            for (int i = 0; i < 7; i++) m_cnt[i] = 0;
        end else if (m_fv) begin
            if (m_cnt[hit] < CMAX) m_cnt[hit]++;
        end else if (m_inv) begin
            if (m_cnt[0] < CMAX) m_cnt[0]++;
        end
    endtask

    task automatic cycle(input logic [6:0] s, input logic clr, input logic [2:0] sel, input logic rst);
        bus.seg       = s;
        bus.clear_cnt = clr;
        bus.cnt_sel   = sel;
        reset         = rst;
        @(posedge clk);
        model_edge(s, clr, rst);
        @(negedge clk);
        chk("face",       32'(bus.face),       32'(m_face));
        chk("face_valid", 32'(bus.face_valid), 32'(m_fv));
        chk("invalid",    32'(bus.invalid),    32'(m_inv));
        chk($sformatf("cnt_out[sel=%0d]", sel), 32'(bus.cnt_out), 32'(exp_cnt(sel)));
        if (bus.face_valid) fv_seen++;
        if (bus.invalid) inv_seen++;
    endtask

    task automatic hold(input logic [6:0] s, input int n, input logic [2:0] sel);
        for (int i = 0; i < n; i++) cycle(s, 1'b0, sel, 1'b0);
    endtask

    initial begin
        logic [6:0] pat;
        int         r;
        bus.seg       = BLANK;
        bus.clear_cnt = 1'b0;
        bus.cnt_sel   = 3'd0;
        reset         = 1'b1;
        for (int i = 0; i < 7; i++) m_cnt[i] = 0;
        @(negedge clk);
        cycle(BLANK, 1'b0, 3'd0, 1'b1);
        cycle(BLANK, 1'b0, 3'd0, 1'b1);
        chk("rst_face",    32'(bus.face),       0);
        chk("rst_valid",   32'(bus.face_valid), 0);
        chk("rst_cnt_out", 32'(bus.cnt_out),    0);
        hold(BLANK, 3, 3'd1);

        // Face 3: pulse exactly after the 5th sampling edge, none while held.
        fv_seen = 0;
        hold(7'b0110000, 4, 3'd3);
        chk("s1_no_early_pulse", fv_seen, 0);
        hold(7'b0110000, 1, 3'd3);
        chk("s1_pulse_5th",      32'(bus.face_valid), 1);
        chk("s1_face",           32'(bus.face), 3);
        hold(7'b0110000, 6, 3'd3);
        chk("s1_single_pulse",   fv_seen, 1);

        // Short face-5 glitch, then face 6.
        fv_seen = 0;
        hold(7'b0010010, 3, 3'd5);
        hold(7'b0000010, 5, 3'd6);
        chk("s2_pulses", fv_seen, 1);
        chk("s2_face",   32'(bus.face), 6);

        // All segments lit is not a face.
        inv_seen = 0;
        fv_seen  = 0;
        hold(7'b0000000, 6, 3'd0);
        chk("s3_invalid", inv_seen, 1);
        chk("s3_nofv",    fv_seen, 0);
        chk("s3_face",    32'(bus.face), 6);
        chk("s3_cnt_inv", 32'(bus.cnt_out), STATS_EN ? 1 : 0);

        // Face 2, blank, face 2; then again with clear on the acceptance edge.
        fv_seen = 0;
        hold(7'b0100100, 6, 3'd2);
        hold(BLANK, 6, 3'd2);
        hold(7'b0100100, 6, 3'd2);
        chk("s4_pulses", fv_seen, 2);
        chk("s4_cnt2",   32'(bus.cnt_out), STATS_EN ? 2 : 0);
        hold(BLANK, 6, 3'd2);
        for (int k = 0; k < 6; k++) cycle(7'b0100100, k == 4, 3'd2, 1'b0);
        chk("s4_pulses_clr", fv_seen, 3);
        chk("s4_cnt2_clr",   32'(bus.cnt_out), 0);

        // Reset mid-settle aborts the pending face 4.
        hold(BLANK, 6, 3'd4);
        fv_seen = 0;
        hold(7'b0011001, 2, 3'd4);
        cycle(7'b0011001, 1'b0, 3'd4, 1'b1);
        chk("s5_rst_face",  32'(bus.face), 0);
        chk("s5_rst_pulse", fv_seen, 0);
        hold(7'b0011001, 4, 3'd4);
        chk("s5_no_early",  fv_seen, 0);
        hold(7'b0011001, 1, 3'd4);
        chk("s5_pulse",     fv_seen, 1);
        chk("s5_face",      32'(bus.face), 4);

        // Saturation of a narrow counter.
        for (int i = 0; i < CMAX + 2; i++) begin
            hold(7'b1111001, 5, 3'd1);
            hold(BLANK, 5, 3'd1);
        end
        chk("sat_cnt1", 32'(bus.cnt_out), STATS_EN ? CMAX : 0);
        for (int s = 0; s < 8; s++) cycle(BLANK, 1'b0, 3'(s), 1'b0);

        // Random pattern runs with occasional clear and reset.
        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 7);
            if (r < 6)       pat = face_tab[r + 1];
            else if (r == 6) pat = BLANK;
            else             pat = 7'($urandom);
            for (int c = $urandom_range(1, 8); c > 0; c--) begin
                cycle(pat, $urandom_range(0, 19) == 0, 3'($urandom_range(0, 7)),
                      $urandom_range(0, 149) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
